// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives pc_next for the PC register, waits out the instruction-memory
// latency and hands each fetched word to decode, with redirect and HALT support.
module fetch_sequencer #(
    parameter int          IMEM_DEPTH = 32,
    parameter int          MEM_WAIT   = 1,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        dec_ready,
    output logic [31:0] pc_next,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        halted,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Word-aligned mask of the instruction byte space.
    localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH * 4 - 1) & 32'hFFFF_FFFC;
    localparam logic [3:0]  WAIT_LOAD = 4'(MEM_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        sample;
    logic [31:0] pc_inc;
    logic [31:0] redirect_pc;

    assign pc_inc      = (pc + 32'd4) & ADDR_MASK;
    assign redirect_pc = redirect_target & ADDR_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            instr_out <= 32'd0;
            instr_pc  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (sample) begin
                instr_out <= instr;
                instr_pc  <= pc;
            end
        end
    end

    // A redirect outranks both the memory-wait countdown and the decode hand-off.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sample    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end else if (cnt == 4'd0) begin
                    if (instr == HALT_WORD) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_ISSUE;
                        sample    = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ISSUE: begin
                if (redirect_valid || dec_ready) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Handshake: a word transfers on a rising edge where instr_valid=1, dec_ready=1 and
    // redirect_valid=0; instr_out/instr_pc hold steady while instr_valid=1 and no transfer occurs.
    always_comb begin
        pc_next     = pc;
        instr_valid = (state == S_ISSUE);
        halted      = (state == S_HALT);
        busy        = (state == S_WAIT) || (state == S_ISSUE);
        case (state)
            S_WAIT: begin
                if (redirect_valid) pc_next = redirect_pc;
            end
            S_ISSUE: begin
                if (redirect_valid) pc_next = redirect_pc;
                else if (dec_ready) pc_next = pc_inc;
            end
            S_HALT: begin
                if (start) pc_next = pc_inc;
            end
            default: pc_next = pc;
        endcase
    end

endmodule
